// File: rtl/ascii_tile_scheduler.sv
// ascii_tile_scheduler
//
// Walks a frame tile by tile in raster order. Each tile goes through three steps:
//   1. fetch it into the shader,
//   2. let the shader run,
//   3. write the result back.
// Optional build macro:
//   ASCII_SCHED_TIMEOUT_EN  enables the shade watchdog. When a tile's shader result
//                           does not arrive in time, the tile is skipped, the sticky
//                           timeout_err flag is set, and the scheduler moves on.
//
// Ports:
//   clk, rst               rising-edge clock, synchronous active-high reset
//   start, abort           begin a frame (IDLE only) / cancel a frame (any other state)
//   fetch_req/fetch_ack    tile-load handshake; fetch_tx/fetch_ty give the tile
//   shade_en/shade_valid   shader enable and its result strobe
//   wb_req/wb_ack          write-back handshake; wb_tx/wb_ty give the tile
//   busy                   high whenever the scheduler is not in IDLE
//   done                   one-cycle pulse at the end of a frame
//   tile_count             number of tiles completed in this frame
//   timeout_err            sticky watchdog flag; always 0 without the macro
//
// Handshake semantics: a req is a level that stays high, with its coordinates
// stable, for as long as the FSM sits in that state. The matching ack or strobe
// is sampled only while its own req/enable is high. It is accepted on the same
// clock edge. Outside its own state it has no effect.

module ascii_tile_scheduler #(
    parameter int WIDTH          = 640,
    parameter int HEIGHT         = 480,
    parameter int TILE_WIDTH     = 8,
    parameter int TILE_HEIGHT    = 8,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int TILES_X = WIDTH / TILE_WIDTH,
    localparam int TILES_Y = HEIGHT / TILE_HEIGHT,
    localparam int TX_W    = $clog2(TILES_X),
    localparam int TY_W    = $clog2(TILES_Y),
    localparam int CNT_W   = $clog2(TILES_X * TILES_Y + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             fetch_req,
    input  logic             fetch_ack,
    output logic [TX_W-1:0]  fetch_tx,
    output logic [TY_W-1:0]  fetch_ty,
    output logic             shade_en,
    input  logic             shade_valid,
    output logic             wb_req,
    input  logic             wb_ack,
    output logic [TX_W-1:0]  wb_tx,
    output logic [TY_W-1:0]  wb_ty,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] tile_count,
    output logic             timeout_err
);

    localparam int TM_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SHADE = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [TX_W-1:0]  tx_q, tx_d;
    logic [TY_W-1:0]  ty_q, ty_d;
    logic [CNT_W-1:0] count_q, count_d;
    // SHADE cycle counter. It is cleared on SHADE entry and saturates.
    // A value of zero marks the first SHADE cycle, whose strobe is ignored.
    logic [TM_W-1:0]  timer_q, timer_d;
    logic             advance;
`ifdef ASCII_SCHED_TIMEOUT_EN
    logic             err_q, err_d;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tx_q    <= '0;
            ty_q    <= '0;
            count_q <= '0;
            timer_q <= '0;
`ifdef ASCII_SCHED_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            count_q <= count_d;
            timer_q <= timer_d;
`ifdef ASCII_SCHED_TIMEOUT_EN
            err_q   <= err_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        count_d = count_q;
        timer_d = timer_q;
        advance = 1'b0;
`ifdef ASCII_SCHED_TIMEOUT_EN
        err_d   = err_q;
`endif
        // Abort wins over any ack that arrives in the same cycle.
        // Nothing else updates in that cycle.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_FETCH;
                        tx_d    = '0;
                        ty_d    = '0;
                        count_d = '0;
`ifdef ASCII_SCHED_TIMEOUT_EN
                        err_d   = 1'b0;
`endif
                    end
                end
                S_FETCH: begin
                    if (fetch_ack) begin
                        state_d = S_SHADE;
                        timer_d = '0;
                    end
                end
                S_SHADE: begin
                    if (timer_q != TM_W'(TIMEOUT_CYCLES)) begin
                        timer_d = timer_q + 1'b1;
                    end
                    if (timer_q != '0 && shade_valid) begin
                        state_d = S_WRITE;
`ifdef ASCII_SCHED_TIMEOUT_EN
                    end else if (timer_q == TM_W'(TIMEOUT_CYCLES - 1)) begin
                        // The last allowed SHADE cycle passed with no result.
                        // Skip the write-back for this tile.
                        err_d   = 1'b1;
                        advance = 1'b1;
`endif
                    end
                end
                S_WRITE: begin
                    if (wb_ack) begin
                        advance = 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            // Raster-order tile advance. The coordinates stay put after the last tile.
            if (advance) begin
                count_d = count_q + 1'b1;
                state_d = S_FETCH;
                if (tx_q == TX_W'(TILES_X - 1)) begin
                    if (ty_q == TY_W'(TILES_Y - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        tx_d = '0;
                        ty_d = ty_q + 1'b1;
                    end
                end else begin
                    tx_d = tx_q + 1'b1;
                end
            end
        end
    end

    // Output decode: every output is a function of the registered state only.
    always_comb begin
        busy       = (state_q != S_IDLE);
        fetch_req  = (state_q == S_FETCH);
        shade_en   = (state_q == S_SHADE);
        wb_req     = (state_q == S_WRITE);
        done       = (state_q == S_DONE);
        fetch_tx   = tx_q;
        fetch_ty   = ty_q;
        wb_tx      = tx_q;
        wb_ty      = ty_q;
        tile_count = count_q;
    end

`ifdef ASCII_SCHED_TIMEOUT_EN
    assign timeout_err = err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ascii_tile_scheduler.sv
// Directed testbench for ascii_tile_scheduler.
// Frame configuration: 32x16 pixels with 8x8 tiles, giving a 4x2 tile grid.
// TIMEOUT_CYCLES is set to 4.
// Cycle numbering: cycle 1 is the cycle right after the clock edge that samples start.

module tb_ascii_tile_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       fetch_req;
    logic       fetch_ack;
    logic [1:0] fetch_tx;
    logic [0:0] fetch_ty;
    logic       shade_en;
    logic       shade_valid;
    logic       wb_req;
    logic       wb_ack;
    logic [1:0] wb_tx;
    logic [0:0] wb_ty;
    logic       busy;
    logic       done;
    logic [3:0] tile_count;
    logic       timeout_err;

    int vectors     = 0;
    int miscompares = 0;

    ascii_tile_scheduler #(
        .WIDTH          (32),
        .HEIGHT         (16),
        .TILE_WIDTH     (8),
        .TILE_HEIGHT    (8),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .fetch_req   (fetch_req),
        .fetch_ack   (fetch_ack),
        .fetch_tx    (fetch_tx),
        .fetch_ty    (fetch_ty),
        .shade_en    (shade_en),
        .shade_valid (shade_valid),
        .wb_req      (wb_req),
        .wb_ack      (wb_ack),
        .wb_tx       (wb_tx),
        .wb_ty       (wb_ty),
        .busy        (busy),
        .done        (done),
        .tile_count  (tile_count),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sampling point: after the call returns, the bench sits in cycle 1.
    task automatic start_frame();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b1;   // reset must win over start
        abort       = 1'b0;
        fetch_ack   = 1'b1;
        shade_valid = 1'b1;
        wb_ack      = 1'b1;
        step();
        step();

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fetch_req", fetch_req, 0);
        check("rst_shade_en", shade_en, 0);
        check("rst_wb_req", wb_req, 0);
        check("rst_tile_count", tile_count, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_tx", fetch_tx, 0);
        check("rst_ty", fetch_ty, 0);
        rst   = 1'b0;
        start = 1'b0;
        step();
        check("idle_busy", busy, 0);

        // Full frame with zero wait states.
        // Each tile takes 4 cycles, and done fires in cycle 33.
        start_frame();
        for (int k = 1; k <= 35; k++) begin
            check("t1_fetch_req", fetch_req, (k <= 32 && k % 4 == 1));
            check("t1_shade_en", shade_en, (k <= 32 && (k % 4 == 2 || k % 4 == 3)));
            check("t1_wb_req", wb_req, (k <= 32 && k % 4 == 0));
            check("t1_done", done, (k == 33));
            check("t1_busy", busy, (k <= 33));
            check("t1_count", tile_count, (k - 1) / 4 > 8 ? 8 : (k - 1) / 4);
            if (k <= 32 && k % 4 == 1) begin
                check("t1_fetch_tx", fetch_tx, ((k - 1) / 4) % 4);
                check("t1_fetch_ty", fetch_ty, ((k - 1) / 4) / 4);
            end
            if (k <= 32 && k % 4 == 0) begin
                check("t1_wb_tx", wb_tx, ((k - 1) / 4) % 4);
                check("t1_wb_ty", wb_ty, ((k - 1) / 4) / 4);
            end
            step();
        end

        // fetch_ack is held off for 5 cycles on tile (2,0).
        // The scheduler should stay in FETCH for cycles 9..14.
        start_frame();
        for (int k = 1; k <= 40; k++) begin
            fetch_ack = !(k >= 9 && k <= 13);
            if (k >= 9 && k <= 14) begin
                check("t2_fetch_req", fetch_req, 1);
                check("t2_fetch_tx", fetch_tx, 2);
                check("t2_fetch_ty", fetch_ty, 0);
                check("t2_shade_en", shade_en, 0);
            end
            if (k == 15) check("t2_shade_after", shade_en, 1);
            check("t2_done", done, (k == 38));
            step();
        end
        fetch_ack = 1'b1;
        check("t2_count", tile_count, 8);

        // A strobe in the first SHADE cycle must be ignored
        start_frame();
        step();
        check("t3_shade_first", shade_en, 1);
        step();
        shade_valid = 1'b0;
        for (int k = 3; k <= 4; k++) begin
            check("t3_shade_hold", shade_en, 1);
            check("t3_no_wb", wb_req, 0);
            step();
        end
        check("t3_shade_k5", shade_en, 1);
        shade_valid = 1'b1;
        step();
        check("t3_wb_req", wb_req, 1);
        check("t3_wb_tx", wb_tx, 0);
        check("t3_shade_off", shade_en, 0);
        wb_ack = 1'b0;
        abort  = 1'b1;
        step();
        abort  = 1'b0;
        wb_ack = 1'b1;
        check("t3_abort_busy", busy, 0);
        check("t3_abort_count", tile_count, 0);

        // Abort during the write-back of tile 3 while wb_ack is high.
        // A start pulse in cycle 6 arrives mid-frame and must be ignored.
        start_frame();
        for (int k = 1; k <= 16; k++) begin
            start = (k == 6);
            if (k == 9) begin
                check("t4_start_ignored_tx", fetch_tx, 2);
                check("t4_start_ignored_cnt", tile_count, 2);
            end
            if (k == 16) begin
                check("t4_wb_req", wb_req, 1);
                check("t4_wb_tx", wb_tx, 3);
                check("t4_wb_ty", wb_ty, 0);
                abort = 1'b1;
            end
            step();
        end
        abort = 1'b0;
        check("t4_idle", busy, 0);
        check("t4_count", tile_count, 3);
        for (int k = 0; k < 4; k++) begin
            check("t4_no_done", done, 0);
            check("t4_stay_idle", busy, 0);
            step();
        end
        start_frame();
        check("t4_restart_req", fetch_req, 1);
        check("t4_restart_tx", fetch_tx, 0);
        check("t4_restart_ty", fetch_ty, 0);
        check("t4_restart_cnt", tile_count, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;

        // shade_valid is held low on tile (1,0)
        start_frame();
`ifdef ASCII_SCHED_TIMEOUT_EN
        for (int k = 1; k <= 11; k++) begin
            shade_valid = !(k >= 5 && k <= 9);
            if (k >= 6 && k <= 9) begin
                check("t5_shade_en", shade_en, 1);
                check("t5_no_wb", wb_req, 0);
            end
            if (k == 10) begin
                check("t5_next_fetch", fetch_req, 1);
                check("t5_next_tx", fetch_tx, 2);
                check("t5_next_ty", fetch_ty, 0);
                check("t5_err", timeout_err, 1);
                check("t5_count", tile_count, 2);
            end
            if (k == 11) check("t5_err_sticky", timeout_err, 1);
            step();
        end
        shade_valid = 1'b1;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5_err_after_abort", timeout_err, 1);
        start_frame();
        check("t5_err_cleared", timeout_err, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
`else
        for (int k = 1; k <= 106; k++) begin
            shade_valid = (k < 5);
            if (k >= 6) check("t5_no_wb", wb_req, 0);
            step();
        end
        check("t5_still_shade", shade_en, 1);
        check("t5_no_err", timeout_err, 0);
        check("t5_count", tile_count, 1);
        shade_valid = 1'b1;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5_abort_idle", busy, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
